pixie_scanout_gen: RTL and testbench
====================================

# pixie_scanout_gen

Parametrised raster back end for the Pixie (CDP1861-style) display path. It scans a byte-wide monochrome frame buffer, 8 pixels per byte, MSB first. It generates horizontal/vertical counters, a frame-buffer read strobe and address, and serialised video. All sync and blanking outputs are aligned to that video. Beyond the fixed-timing back end it adds: a pixel clock enable, a synchronous reset, programmable raster geometry, vertical line repeat (scaling), a frame-latched display-enable input, and a frame-start pulse.

## Interface
Parameters:
- `H_TOTAL`, 112: pixel clocks per line.
- `H_ACTIVE`, 64: active pixels per line; must be a multiple of 8, and `H_ACTIVE/8` must be a power of two.
- `HS_START`, 80: counter position of the first hsync pixel.
- `HS_WIDTH`, 12: hsync width in pixels.
- `V_TOTAL`, 262: lines per frame.
- `V_ACTIVE`, 128: active lines per frame.
- `VS_START`, 182: first vsync line.
- `VS_HEIGHT`, 16: vsync height in lines.
- `LINE_REPEAT`, 1: output lines per frame-buffer row, range 1..4. `V_ACTIVE/LINE_REPEAT` must be a power of two.
- Derived localparam `FB_AW` = clog2(H_ACTIVE/8) + clog2(V_ACTIVE/LINE_REPEAT), which is 10 at the defaults.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `ce_pix` in 1: pixel clock enable. All state advances only on `clk` edges where `ce_pix`=1.
- `display_on` in 1: display enable; sampled once per frame.
- `fb_read_en` out 1: frame-buffer read strobe.
- `fb_addr` out FB_AW: frame-buffer byte address, laid out as {row, byte-in-row}.
- `fb_data` in 8: read data, valid one ce cycle after `fb_read_en`.
- `video` out 1: pixel output.
- `HSync`, `VSync` out 1: active-high sync.
- `csync` out 1: `HSync` XOR `VSync`.
- `HBlank`, `VBlank` out 1: high outside the active region.
- `video_de` out 1: high = active region, equal to NOT(HBlank OR VBlank).
- `frame_start` out 1: one-ce pulse at the first pixel of a frame.

## Operation
- **Horizontal counter:** `h` counts 0..H_TOTAL-1 and wraps to 0.
- **Vertical counter:** `v` increments on each `h` wrap, counts 0..V_TOTAL-1 and wraps to 0.
- **Row addressing:** `lr` counts 0..LINE_REPEAT-1 and advances on each `h` wrap while `v`<V_ACTIVE. `row` increments when `lr` wraps. `lr` and `row` both clear on `v` wrap.
- **Address:** `fb_addr` = {row, h[clog2(H_ACTIVE/8)+2:3]}. It is combinational from the counters and is meaningful only while `fb_read_en`=1.
- **Display enable latch:** `disp_q` samples `display_on` at the ce where h=0 and v=0. A mid-frame change has no effect until the next frame.
- **Read strobe:** `fb_read_en`=1 for exactly one ce cycle when h[2:0]=0, h<H_ACTIVE, v<V_ACTIVE and `disp_q`=1. Otherwise it is 0, so there are no reads in blanking or while the display is off.
- **Shift register:** it loads `fb_data` at the ce where h[2:0]=1 and shifts left (LSB fill 0) on every other ce. Loading occurs only if a read was issued for that byte; otherwise it loads 0.
- **Video:** `video` = shift-register bit 7 AND active AND `disp_q`. Pixel h shows bit (7 − h[2:0]) of its byte.
- **Sync and blanking:**
  - Hsync is active for HS_START ≤ h < HS_START+HS_WIDTH.
  - Vsync is active for VS_START ≤ v < VS_START+VS_HEIGHT.
  - HBlank = (h ≥ H_ACTIVE); VBlank = (v ≥ V_ACTIVE).
  - Syncs and blanking run regardless of `disp_q`.
- **Frame start:** `frame_start` is the decode of h=0, v=0.

## Timing
- **Alignment:** all outputs except `fb_read_en`/`fb_addr` are registered and delayed exactly 2 ce cycles from the counter position they describe. `video`, `HSync`, `VSync`, `HBlank`, `VBlank`, `video_de`, `csync` and `frame_start` are therefore mutually aligned with the pixel stream.
- **Read timing:** `fb_read_en`/`fb_addr` lead pixel 8k by 2 ce cycles. Read latency is fixed at 1 ce cycle. `fb_data` must be held stable until the next ce.
- **Clock enable:** when `ce_pix`=0, all registers hold, including the outputs and `fb_read_en`.
- **Reset:** h=v=lr=row=0, `disp_q`=0, shift register 0. Outputs: `fb_read_en`=0, `video`=0, `HSync`=`VSync`=`csync`=0, `HBlank`=`VBlank`=0, `video_de`=0, `frame_start`=0.
- **Leaving reset:** the first ce after reset treats position (0,0) as frame start, so `frame_start` rises 2 ce later. Reset asserted mid-frame aborts the frame; no partial read strobe is held.
- **Reset priority:** reset overrides `ce_pix`.
- **Simultaneous wraps:** when `h` and `v` wrap on the same ce, `row`/`lr` clear and `disp_q` resamples on that same ce.

## Test plan
- **Default geometry, `display_on`=1:** fb[a] = a[7:0]. Check 112 ce per line, 262 lines per frame, and 8 reads per active line. Row 5, byte 3 (addr 43 = 0x2B) must produce pixels 24..31 = 0,0,1,0,1,0,1,1. Check `fb_read_en` count = 1024 per frame.
- **Sync and blanking positions:** `HSync` high for 12 ce starting 2 ce after h=80. `VSync` high for lines 182..197. `video_de` high for exactly 64×128 ce per frame. `csync` = XOR of `HSync` and `VSync` throughout.
- **`LINE_REPEAT`=2, `V_ACTIVE`=128:** output lines 2k and 2k+1 both read row k; `FB_AW`=9. Check 64 distinct rows, each read twice.
- **`display_on` toggled to 0 at v=40:** the current frame is unaffected. The next frame shows zero `fb_read_en` and `video`=0, with syncs unchanged. Re-enabling takes effect only at the following frame start.
- **`ce_pix` pattern 1,0,0 repeating:** output sequence identical to the ce=1 run, stretched ×3. No output changes on a ce=0 cycle.
- **Reset pulse at h=50, v=60:** all outputs match the reset values on the next clk. `frame_start` asserts 2 ce after reset release, and the following frame's pixels match the default-geometry case.

Source files
------------

// File: rtl/pixie_scanout_gen.sv
// Pixie-style raster back end: counters, frame-buffer fetch, serial video.
// Every output except the fetch strobe/address trails the counters by 2 ce.
module pixie_scanout_gen #(
  parameter int H_TOTAL     = 112,
  parameter int H_ACTIVE    = 64,
  parameter int HS_START    = 80,
  parameter int HS_WIDTH    = 12,
  parameter int V_TOTAL     = 262,
  parameter int V_ACTIVE    = 128,
  parameter int VS_START    = 182,
  parameter int VS_HEIGHT   = 16,
  parameter int LINE_REPEAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic ce_pix,
  input  logic display_on,
  output logic fb_read_en,
  output logic [$clog2(H_ACTIVE/8)+$clog2(V_ACTIVE/LINE_REPEAT)-1:0] fb_addr,
  input  logic [7:0] fb_data,
  output logic video,
  output logic HSync,
  output logic VSync,
  output logic csync,
  output logic HBlank,
  output logic VBlank,
  output logic video_de,
  output logic frame_start
);

  localparam int HW    = $clog2(H_TOTAL);
  localparam int VW    = $clog2(V_TOTAL);
  localparam int BW    = $clog2(H_ACTIVE/8);
  localparam int RW    = $clog2(V_ACTIVE/LINE_REPEAT);
  localparam int FB_AW = BW + RW;
  localparam int LRW   = (LINE_REPEAT > 1) ? $clog2(LINE_REPEAT) : 1;

  logic [HW-1:0]    h;
  logic [VW-1:0]    v;
  logic [LRW-1:0]   lr;
  logic [RW-1:0]    row;
  logic             disp_q;
  logic             rd_q;
  logic [7:0]       sr;
  logic [6:0]       p1;
  logic [6:0]       p2;
  logic [FB_AW-1:0] addr;

  logic h_end, v_end, lr_end;
  logic h_act, v_act;
  logic hs_now, vs_now, fs_now;
  logic [6:0] now;

  assign h_end  = (h == HW'(H_TOTAL - 1));
  assign v_end  = (v == VW'(V_TOTAL - 1));
  assign lr_end = (lr == LRW'(LINE_REPEAT - 1));
  assign h_act  = (h < HW'(H_ACTIVE));
  assign v_act  = (v < VW'(V_ACTIVE));

  assign hs_now = (int'(h) >= HS_START) &&
                  (int'(h) < HS_START + HS_WIDTH);
  assign vs_now = (int'(v) >= VS_START) &&
                  (int'(v) < VS_START + VS_HEIGHT);
  assign fs_now = (h == '0) && (v == '0);

  assign now = {disp_q, fs_now, h_act & v_act,
                ~v_act, ~h_act, vs_now, hs_now};

  assign addr       = {row, h[BW+2:3]};
  assign fb_addr    = addr;
  assign fb_read_en = (h[2:0] == 3'd0) & h_act & v_act & disp_q;

  // disp_q resamples on the ce that enters (0,0), so it governs a whole frame
  always_ff @(posedge clk) begin
    if (reset) begin
      h      <= '0;
      v      <= '0;
      lr     <= '0;
      row    <= '0;
      disp_q <= 1'b0;
    end else if (ce_pix) begin
      h <= h_end ? '0 : h + 1'b1;
      if (h_end) begin
        v <= v_end ? '0 : v + 1'b1;
        if (v_end) begin
          lr     <= '0;
          row    <= '0;
          disp_q <= display_on;
        end else if (v_act) begin
          lr <= lr_end ? '0 : lr + 1'b1;
          if (lr_end)
            row <= row + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= 1'b0;
      sr   <= '0;
      p1   <= '0;
      p2   <= '0;
    end else if (ce_pix) begin
      rd_q <= fb_read_en;
      if (h[2:0] == 3'd1)
        sr <= rd_q ? fb_data : 8'd0;
      else
        sr <= {sr[6:0], 1'b0};
      p1 <= now;
      p2 <= p1;
    end
  end

  assign HSync       = p2[0];
  assign VSync       = p2[1];
  assign HBlank      = p2[2];
  assign VBlank      = p2[3];
  assign video_de    = p2[4];
  assign frame_start = p2[5];
  assign csync       = p2[0] ^ p2[1];
  assign video       = sr[7] & p2[4] & p2[6];

endmodule

// File: tb/tb_pixie_scanout_gen.sv
// Bench for pixie_scanout_gen: default and 2x line-repeat instances
// compared every clock against a raster-position reference model.
module tb_pixie_scanout_gen;

  localparam int HT  = 112;
  localparam int HA  = 64;
  localparam int HSS = 80;
  localparam int HSW = 12;
  localparam int VT  = 262;
  localparam int VA  = 128;
  localparam int VSS = 182;
  localparam int VSH = 16;
  localparam int FT  = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, ce_pix, display_on;
  logic rd0, rd1;
  logic [9:0] ad0;
  logic [8:0] ad1;
  logic [7:0] fd0, fd1;
  logic vi0, hs0, vs0, cs0, hb0, vb0, de0, fs0;
  logic vi1, hs1, vs1, cs1, hb1, vb1, de1, fs1;

  pixie_scanout_gen u_def (
    .clk(clk), .reset(reset), .ce_pix(ce_pix),
    .display_on(display_on),
    .fb_read_en(rd0), .fb_addr(ad0), .fb_data(fd0),
    .video(vi0), .HSync(hs0), .VSync(vs0), .csync(cs0),
    .HBlank(hb0), .VBlank(vb0), .video_de(de0),
    .frame_start(fs0)
  );

  pixie_scanout_gen #(.LINE_REPEAT(2)) u_lr2 (
    .clk(clk), .reset(reset), .ce_pix(ce_pix),
    .display_on(display_on),
    .fb_read_en(rd1), .fb_addr(ad1), .fb_data(fd1),
    .video(vi1), .HSync(hs1), .VSync(vs1), .csync(cs1),
    .HBlank(hb1), .VBlank(vb1), .video_de(de1),
    .frame_start(fs1)
  );

  logic [7:0] mem0[1024];
  logic [7:0] mem1[512];
  bit dsp[8];
  int n, total, bad, epoch;
  int cnt_rd0, cnt_rd1, cnt_de0, cnt_off, rows2;
  int rowcnt[64];
  logic [7:0] pix;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 30)
        $display("FAIL %s n=%0d got=%h exp=%h",
                 tag, n, got, exp);
    end
  endtask

  // {rd, addr[9:0], video, hs, vs, hb, vb, de, fs, csync}
  function automatic logic [18:0] model_at(input int which,
                                           input int k);
    int lr, h, ln, fr, a;
    logic rd, vi, hs, vs, hb, vb, de, fs;
    logic [9:0] ad;
    logic [7:0] byt;
    lr = which + 1;
    h  = k % HT;
    ln = (k / HT) % VT;
    fr = k / FT;
    rd = (h % 8 == 0) && (h < HA) && (ln < VA) && dsp[fr];
    ad = rd ? 10'((ln / lr) * 8 + h / 8) : 10'd0;
    {vi, hs, vs, hb, vb, de, fs} = '0;
    if (k >= 2) begin
      h  = (k - 2) % HT;
      ln = ((k - 2) / HT) % VT;
      fr = (k - 2) / FT;
      hs = (h >= HSS) && (h < HSS + HSW);
      vs = (ln >= VSS) && (ln < VSS + VSH);
      hb = (h >= HA);
      vb = (ln >= VA);
      de = !hb && !vb;
      fs = (h == 0) && (ln == 0);
      byt = 8'd0;
      if (de) begin
        a = (ln / lr) * 8 + h / 8;
        byt = which ? mem1[a] : mem0[a];
      end
      vi = de && dsp[fr] && byt[7 - h % 8];
    end
    return {rd, ad, vi, hs, vs, hb, vb, de, fs, hs ^ vs};
  endfunction

  task automatic step(input bit ce);
    logic r0, r1;
    logic [9:0] a0;
    logic [8:0] a1;
    logic [18:0] e, o;
    ce_pix = ce;
    r0 = rd0; a0 = ad0;
    r1 = rd1; a1 = ad1;
    if (!reset && ce && epoch == 1) begin
      if (n >= FT && n < 2 * FT) begin
        cnt_rd0 += int'(r0);
        cnt_rd1 += int'(r1);
        if (r1 && a1[2:0] == 3'd0)
          rowcnt[a1[8:3]]++;
      end
      if (n >= 2 * FT)
        cnt_off += int'(r0) + int'(r1);
    end
    @(posedge clk);
    #1;
    if (reset) begin
      n = 0;
      foreach (dsp[i]) dsp[i] = 1'b0;
    end else if (ce) begin
      if (n % FT == FT - 1)
        dsp[n / FT + 1] = display_on;
      n++;
      fd0 = r0 ? mem0[a0] : 8'($urandom);
      fd1 = r1 ? mem1[a1] : 8'($urandom);
    end
    @(negedge clk);
    e = model_at(0, n);
    o = {rd0, e[18] ? ad0 : 10'd0,
         vi0, hs0, vs0, hb0, vb0, de0, fs0, cs0};
    check("dut_def", 32'(o), 32'(e));
    e = model_at(1, n);
    o = {rd1, e[18] ? {1'b0, ad1} : 10'd0,
         vi1, hs1, vs1, hb1, vb1, de1, fs1, cs1};
    check("dut_lr2", 32'(o), 32'(e));
    if (ce && !reset && epoch == 1) begin
      if (n >= FT + 2 && n < 2 * FT + 2)
        cnt_de0 += int'(de0);
      if (n >= FT + 5 * HT + 26 && n <= FT + 5 * HT + 33)
        pix = {pix[6:0], vi0};
    end
  endtask

  initial begin
    total = 0; bad = 0; n = 0; epoch = 0;
    cnt_rd0 = 0; cnt_rd1 = 0; cnt_de0 = 0; cnt_off = 0;
    pix = 8'd0;
    foreach (rowcnt[i]) rowcnt[i] = 0;
    foreach (dsp[i]) dsp[i] = 1'b0;
    for (int i = 0; i < 1024; i++) mem0[i] = 8'(i);
    for (int i = 0; i < 512; i++) mem1[i] = 8'($urandom);
    reset = 1'b1; ce_pix = 1'b1; display_on = 1'b1;
    fd0 = 8'd0; fd1 = 8'd0;
    @(negedge clk);
    repeat (3) step(1'b1);
    check("rst_de", 32'(de0), 32'd0);
    check("rst_rd", 32'(rd0), 32'd0);
    reset = 1'b0;
    epoch = 1;
    while (n < 2 * FT) begin
      if (n == FT + 40 * HT) display_on = 1'b0;
      step(1'b1);
    end
    check("f1_reads", cnt_rd0, 1024);
    check("f1_de", cnt_de0, HA * VA);
    check("lr2_reads", cnt_rd1, 1024);
    rows2 = 0;
    foreach (rowcnt[i]) if (rowcnt[i] == 2) rows2++;
    check("lr2_rows", rows2, 64);
    check("px_2b", 32'(pix), 32'h2b);
    while (n < 2 * FT + 50 * HT) step(1'b1);
    display_on = 1'b1;
    while (n < 2 * FT + 60 * HT + 50) step(1'b1);
    check("off_reads", cnt_off, 0);
    reset = 1'b1;
    step(1'b0);
    check("mid_rst_hb", 32'(hb0), 32'd0);
    check("mid_rst_vi", 32'(vi0), 32'd0);
    reset = 1'b0;
    epoch = 2;
    while (n < 6 * HT) begin
      step(1'b1);
      step(1'b0);
      step(1'b0);
    end
    for (int i = 0; i < 4000 && n < 12 * HT; i++)
      step(1'($urandom_range(0, 1)));
    check("rand_done", 32'(n >= 12 * HT), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
